// File: rtl/led_pkg.sv
// Shared constants and types for the HUB75 scan engine and the top-level pin packing.
package led_pkg;

    localparam int PANEL_W    = 64;
    localparam int HALF_ROWS  = 32;
    localparam int COL_PHASES = 4;

    typedef enum logic [1:0] {
        SHIFT = 2'd0,
        BLANK = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Bit positions inside LED_PANEL[15:0] as packed by top
    localparam int LP_R0       = 0;
    localparam int LP_G0       = 1;
    localparam int LP_B0       = 2;
    localparam int LP_R1       = 3;
    localparam int LP_G1       = 4;
    localparam int LP_B1       = 5;
    localparam int LP_ADDR_LSB = 6;
    localparam int LP_SCLK     = 11;
    localparam int LP_LAT      = 12;
    localparam int LP_OE       = 13;

    // Row index queried for the bottom half: the top-half row with bit 5 set, no carry.
    function automatic logic [5:0] bottom_y(input logic [4:0] row);
        return {1'b1, row};
    endfunction

endpackage

// File: rtl/led_scanner_if.sv
// Painter query bus plus HUB75 panel pins driven by the scan engine.
interface led_scanner_if;
    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [2:0]  rgb;
    logic        r0, g0, b0;
    logic        r1, g1, b1;
    logic [4:0]  addr;
    logic        sclk;
    logic        lat;
    logic        oe;

    modport master (
        output frame, subframe, x, y,
        input  rgb,
        output r0, g0, b0, r1, g1, b1, addr, sclk, lat, oe
    );

    modport slave (
        input  frame, subframe, x, y,
        output rgb,
        input  r0, g0, b0, r1, g1, b1, addr, sclk, lat, oe
    );
endinterface

// File: rtl/led_scanner_frame_counter.sv
// Subframe/frame counter advanced by one tick per completed panel scan.
module frame_counter #(
    parameter int SUBFRAMES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    output logic [7:0]  subframe,
    output logic [12:0] frame
);

    localparam logic [7:0] SUB_LAST = 8'(SUBFRAMES - 1);

    // Subframe wraps at SUBFRAMES-1 and carries into the free-running 13-bit frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            subframe <= 8'd0;
            frame    <= 13'd0;
        end else if (tick) begin
            if (subframe == SUB_LAST) begin
                subframe <= 8'd0;
                frame    <= frame + 13'd1;
            end else begin
                subframe <= subframe + 8'd1;
            end
        end
    end

endmodule

// File: rtl/led_scanner.sv
// HUB75 1/32-scan engine for a 64x64 panel: queries the painter, shifts two rows, blanks, latches.
module led_scanner
    import led_pkg::*;
#(
    parameter int SUBFRAMES = 256
) (
    input  logic          clk,
    input  logic          reset,
    led_scanner_if.master bus
);

    state_t      state_r;
    logic [5:0]  col_r;
    logic [1:0]  phase_r;
    logic [4:0]  row_r;
    logic        primed_r;
    logic [2:0]  top_r;
    logic [5:0]  x_r;
    logic [5:0]  y_r;
    logic [2:0]  data0_r;
    logic [2:0]  data1_r;
    logic [4:0]  addr_r;
    logic        sclk_r;
    logic        lat_r;
    logic        oe_r;
    logic        tick_s;
    logic [7:0]  subframe_s;
    logic [12:0] frame_s;

    // Counters step on the last row's latch so row 0 of the next scan sees the new values.
    assign tick_s = (state_r == LATCH) && (row_r == 5'(HALF_ROWS - 1));

    frame_counter #(.SUBFRAMES(SUBFRAMES)) u_frame_counter (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick_s),
        .subframe (subframe_s),
        .frame    (frame_s)
    );

    // Scan sequencer: four phases per column, then one blank and one latch cycle per row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= SHIFT;
            col_r    <= 6'd0;
            phase_r  <= 2'd0;
            row_r    <= 5'd0;
            primed_r <= 1'b0;
            top_r    <= 3'd0;
            x_r      <= 6'd0;
            y_r      <= 6'd0;
            data0_r  <= 3'd0;
            data1_r  <= 3'd0;
            addr_r   <= 5'd0;
            sclk_r   <= 1'b0;
            lat_r    <= 1'b0;
            oe_r     <= 1'b1;
        end else begin
            case (state_r)
                SHIFT: begin
                    phase_r <= phase_r + 2'd1;
                    case (phase_r)
                        2'd0: begin
                            top_r <= bus.rgb;
                            y_r   <= bottom_y(row_r);
                        end
                        2'd1: begin
                            // Bottom colour goes straight to the pins; it is captured the same edge.
                            data0_r <= top_r;
                            data1_r <= bus.rgb;
                        end
                        2'd2: begin
                            sclk_r <= 1'b1;
                        end
                        default: begin
                            sclk_r <= 1'b0;
                            if (col_r == 6'(PANEL_W - 1)) begin
                                state_r <= BLANK;
                                oe_r    <= 1'b1;
                            end else begin
                                col_r <= col_r + 6'd1;
                                x_r   <= col_r + 6'd1;
                                y_r   <= {1'b0, row_r};
                            end
                        end
                    endcase
                end
                BLANK: begin
                    state_r  <= LATCH;
                    lat_r    <= 1'b1;
                    addr_r   <= row_r;
                    primed_r <= 1'b1;
                end
                LATCH: begin
                    state_r <= SHIFT;
                    lat_r   <= 1'b0;
                    oe_r    <= ~primed_r;
                    row_r   <= row_r + 5'd1;
                    col_r   <= 6'd0;
                    phase_r <= 2'd0;
                    x_r     <= 6'd0;
                    y_r     <= {1'b0, row_r + 5'd1};
                end
                default: begin
                    state_r <= SHIFT;
                    sclk_r  <= 1'b0;
                    lat_r   <= 1'b0;
                    oe_r    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.frame    = frame_s;
    assign bus.subframe = subframe_s;
    assign bus.x        = x_r;
    assign bus.y        = y_r;
    assign bus.r0       = data0_r[2];
    assign bus.g0       = data0_r[1];
    assign bus.b0       = data0_r[0];
    assign bus.r1       = data1_r[2];
    assign bus.g1       = data1_r[1];
    assign bus.b1       = data1_r[0];
    assign bus.addr     = addr_r;
    assign bus.sclk     = sclk_r;
    assign bus.lat      = lat_r;
    assign bus.oe       = oe_r;

endmodule

// File: tb/tb_led_scanner.sv
// Randomised bench for led_scanner: a cycle-indexed reference derived from the scan timing rules.
module tb_led_scanner;

    localparam int SUBF    = 4;
    localparam int ROW_CYC = 258;
    localparam int SUB_CYC = 32 * ROW_CYC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] pix [0:63][0:63];

    led_scanner_if bus();
    assign bus.rgb = pix[bus.y][bus.x];

    led_scanner #(.SUBFRAMES(SUBF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic        fc_tick;
    logic [7:0]  fc_sub;
    logic [12:0] fc_frame;

    frame_counter #(.SUBFRAMES(1)) u_fc (
        .clk      (clk),
        .reset    (reset),
        .tick     (fc_tick),
        .subframe (fc_sub),
        .frame    (fc_frame)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected panel/painter state for cycle n after reset release.
    task automatic check_cycle(input int n);
        int k, rc, r, col, ph, sub_idx, e_addr, e_x, e_y;
        logic e_oe, e_lat, e_sclk, chk_xy;
        logic [7:0]  ctl_got, ctl_exp;
        logic [5:0]  d_got, d_exp;
        k       = n % ROW_CYC;
        rc      = n / ROW_CYC;
        r       = rc % 32;
        col     = k / 4;
        ph      = k % 4;
        sub_idx = n / SUB_CYC;
        e_addr  = (rc == 0) ? 0 : ((rc - 1) % 32);
        e_x     = 63;
        e_y     = r + 32;
        chk_xy  = 1'b1;
        if (k < 256) begin
            e_sclk = (ph == 3);
            e_lat  = 1'b0;
            e_oe   = (rc == 0);
            e_x    = col;
            e_y    = (ph == 0) ? r : r + 32;
            chk_xy = (ph < 2);
            if (ph == 3) begin
                d_got = {bus.r0, bus.g0, bus.b0, bus.r1, bus.g1, bus.b1};
                d_exp = {pix[r][col], pix[r + 32][col]};
                check_eq("data", 32'(d_got), 32'(d_exp));
            end
        end else if (k == 256) begin
            e_sclk = 1'b0;
            e_lat  = 1'b0;
            e_oe   = 1'b1;
        end else begin
            e_sclk = 1'b0;
            e_lat  = 1'b1;
            e_oe   = 1'b1;
            e_addr = r;
        end
        ctl_got = {bus.oe, bus.lat, bus.sclk, bus.addr};
        ctl_exp = {e_oe, e_lat, e_sclk, 5'(e_addr)};
        check_eq("ctl", 32'(ctl_got), 32'(ctl_exp));
        if (chk_xy) check_eq("xy", {20'd0, bus.x, bus.y}, {20'd0, 6'(e_x), 6'(e_y)});
        check_eq("cnt", {11'd0, bus.frame, bus.subframe},
                 {11'd0, 13'((sub_idx / SUBF) % 8192), 8'(sub_idx % SUBF)});
    endtask

    initial begin
        int n, target, tcount;
        fc_tick = 1'b0;
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 64; xx++)
                pix[yy][xx] = 3'($urandom_range(0, 7));

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Several subframes of random imagery, stopping mid-shift at row 7 col 20 with sclk high.
        target = 5 * SUB_CYC + 7 * ROW_CYC + 20 * 4 + 3;
        n = 0;
        check_cycle(n);
        while (n < target) begin
            @(posedge clk);
            #2;
            n++;
            check_cycle(n);
        end

        reset = 1'b1;
        #1;
        check_eq("rst_async", {29'd0, bus.sclk, bus.lat, bus.oe}, 32'b001);

        repeat (3) @(posedge clk);
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 64; xx++)
                pix[yy][xx] = (yy < 32) ? 3'b101 : 3'b010;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n = 0;
        check_cycle(n);
        while (n < 3 * ROW_CYC) begin
            @(posedge clk);
            #2;
            n++;
            check_cycle(n);
        end

        // Standalone counter with one subframe per frame: exercise the 8191 -> 0 frame wrap.
        tcount = 0;
        for (int i = 0; i < 11000; i++) begin
            @(negedge clk);
            fc_tick = ($urandom_range(0, 7) != 0);
            @(posedge clk);
            #2;
            if (fc_tick) tcount++;
            check_eq("fc", {11'd0, fc_frame, fc_sub}, {11'd0, 13'(tcount % 8192), 8'd0});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_scanner.md
# led_scanner

Scan engine that drives a 64x64, 1/32-scan HUB75 LED panel and supplies the painter pixel interface. It generates `frame`, `subframe`, `x` and `y`, samples the painter's combinational `rgb`, shifts the two half-panel rows out with `sclk`, and sequences blanking, latch and row address. It sits between `led_main`'s clock and reset and the `LED_PANEL` pins. `top` packs its panel outputs into `LED_PANEL[15:0]`.

## Interface

Parameters:
- `SUBFRAMES`, default 256: subframes per frame, legal range 1..256.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `frame`  out  13  frame counter to the painter.
- `subframe`  out  8  subframe counter to the painter.
- `x`  out  6  pixel column being queried.
- `y`  out  6  pixel row being queried.
- `rgb`  in  3  painter colour {r,g,b}; combinational from `x`/`y`.
- `r0`, `g0`, `b0`  out  1 each  top-half data (panel rows 0..31).
- `r1`, `g1`, `b1`  out  1 each  bottom-half data (panel rows 32..63).
- `addr`  out  5  panel row address.
- `sclk`  out  1  panel shift clock.
- `lat`  out  1  panel latch strobe.
- `oe`  out  1  panel output enable, active-low (1 = blanked).

## Operation

- State machine states: SHIFT, BLANK, LATCH. Internal counters: `col` (6 bits), `phase` (2 bits), `row` (5 bits), plus a `primed` flag.
- **SHIFT** takes 4 cycles per column, 64 columns, so 256 cycles per row.
  - phase 0: `x=col`, `y=row`. At the end of the cycle, `rgb` is captured into the top register.
  - phase 1: `x=col`, `y=row+32`. At the end of the cycle, `rgb` is captured into the bottom register.
  - phase 2: data outputs are loaded from the captured registers and `sclk=0`.
  - phase 3: `sclk=1` with data held stable.
- After col 63, phase 3, the FSM goes to **BLANK** for 1 cycle: `oe=1`, `sclk=0`.
- It then goes to **LATCH** for 1 cycle: `lat=1` and `addr<=row`. `primed` is set.
- It then returns to SHIFT with `row+1` (modulo 32), `col=0`, `phase=0`.
- During SHIFT, `oe=~primed`, so the previously latched row is displayed while the next row shifts. `oe=1` in BLANK and LATCH.
- Counter advance on the LATCH of row 31:
  - `subframe` increments; when it equals `SUBFRAMES-1` it wraps to 0 and `frame` increments.
  - `frame` wraps 8191 -> 0.
  - The new values are visible from the first SHIFT cycle of row 0, so a row is never painted with mixed subframe values.
- `x`/`y` hold their last values through BLANK and LATCH.
- Widths: `y=row+32` is `{1'b1,row}`, with no carry.

## Timing

- Reset values: `frame=0`, `subframe=0`, `x=0`, `y=0`, `r0..b1=0`, `addr=0`, `sclk=0`, `lat=0`, `oe=1`, `primed=0`. The state is SHIFT with row 0, col 0, phase 0.
- Reset is asynchronous. Asserting it mid-SHIFT forces `oe=1` and `sclk=0` immediately, without waiting for a clock edge.
- Painter latency: 0 cycles. `rgb` must settle within the same cycle `x`/`y` are presented.
- Data outputs change only in phase 2 while `sclk=0`. The panel samples on the `sclk` rising edge, one cycle later.
- Periods:
  - row: 258 cycles.
  - subframe: 32*258 = 8256 cycles.
  - frame: `SUBFRAMES`*8256 cycles.
- `lat` is high for exactly 1 cycle per row and never coincides with `sclk=1` or `oe=0`.
- First row after reset: `oe` stays 1 until after the first LATCH.

## Structure

- A shared package `led_pkg` holds the constants:
  - `PANEL_W=64`, `HALF_ROWS=32`.
  - `COL_PHASES=4`.
  - The state enum {SHIFT, BLANK, LATCH}.
  - The bit positions of `LED_PANEL` used by `top`.
- One sub-module is natural: `frame_counter`. Inputs: `clk`, `reset`, `tick`. Outputs: `subframe`, `frame`. It handles the `SUBFRAMES` wrap and the frame wrap, and is reusable by other scanners.

## Test plan

- Reset check: hold `reset` 3 cycles and release -> `oe=1`, `lat=0`, `sclk=0`, `addr=0`, `frame=0`, `subframe=0`, `x=0`, `y=0`. First `x`/`y` sequence is (0,0),(0,32), then `sclk` rises at cycle 3.
- Painter stub returning `rgb=3'b101` when `y<32` and `3'b010` otherwise -> on every `sclk` rise, `{r0,g0,b0}=101` and `{r1,g1,b1}=010`. Exactly 64 `sclk` rises per row.
- Row sequencing -> `lat` pulses every 258 cycles. `addr` takes 0,1,…,31,0. `oe` is 1 until the first latch, then 0 only during SHIFT.
- `SUBFRAMES=4` -> `subframe` steps 0,1,2,3,0 every 8256 cycles. `frame` increments on the 3->0 wrap. The change is visible at row 0 col 0 phase 0.
- Force `frame=8191` with `subframe` at its last value -> at the next row-31 LATCH, `frame=0`.
- Assert `reset` asynchronously mid-SHIFT (row 7, col 20, `sclk=1`) -> `sclk` and `lat` go 0 and `oe` goes 1 before the next edge. After release, the sequence restarts at row 0, col 0 with `primed=0`.
